usb_frame_scheduler: RTL and testbench
======================================

// Module: usb_frame_scheduler
// PURPOSE
//  Round-robin scheduler that shares the single 16-bit USB output path (usb_data_out) between
//  NUM_CH beamformed sample streams. It grants one channel at a time and emits one framed
//  burst per grant: header word, channel-ID word, then FRAME_LEN samples.
//  Sits between the beamformer channel outputs and the USB transmit FIFO write port.
// PARAMETERS
//  NUM_CH     4         number of requesting sample streams (2..16)
//  DATA_W     16        sample / USB word width
//  FRAME_LEN  64        samples per granted burst (>=1)
//  HDR_WORD   16'hA5A5  frame header word written first in every frame
// PORTS
//  clk           in   1              system clock; all logic on rising edge
//  rst           in   1              synchronous reset, active-high
//  enable        in   1              allow new frames to start
//  ch_valid      in   NUM_CH         per-channel sample valid
//  ch_data       in   NUM_CH*DATA_W  per-channel sample; channel i at [i*DATA_W +: DATA_W]
//  ch_ready      out  NUM_CH         per-channel accept strobe (combinational)
//  usb_full      in   1              USB FIFO almost-full (asserted with >=1 free entry left)
//  usb_wr_en     out  1              registered write strobe to USB FIFO
//  usb_data_out  out  DATA_W         registered write data, valid when usb_wr_en=1
//  busy          out  1              registered; high while not in IDLE
//  frame_done    out  1              registered one-cycle pulse after last sample of a frame is written
// BEHAVIOUR
//  Reset: state=IDLE, usb_wr_en=0, usb_data_out=0, busy=0, frame_done=0, ch_ready=0,
//   sample count=0, last-grant pointer=NUM_CH-1 (so ch0 has first priority).
//  FSM states: IDLE, HDR, CHID, DATA.
//   IDLE: if enable && |ch_valid -> latch grant = first requesting channel searching
//     last+1, last+2, ... (mod NUM_CH); update last-grant pointer; -> HDR. No write.
//   HDR:  if !usb_full -> write HDR_WORD; -> CHID. Else hold.
//   CHID: if !usb_full -> write {zero-extend(grant)}; -> DATA. Else hold.
//   DATA: ch_ready[grant] = !usb_full && ch_valid[grant]; all other ch_ready bits 0.
//     On each accept: write ch_data[grant], count++. On accept with count==FRAME_LEN-1:
//     count<=0, -> IDLE, frame_done pulses in the next cycle (same cycle usb_wr_en shows that last sample).
//     ch_valid[grant] low: wait, no write, no timeout (underrun stalls the frame).
//  Write timing: decision made in cycle N (from usb_full sampled in N) -> usb_wr_en/usb_data_out
//   asserted in cycle N+1 for exactly one cycle per word. usb_full is almost-full to cover this latency.
//  ch_ready is a pure function of state, grant, usb_full, ch_valid; producer pops on ch_valid&&ch_ready.
//  Ordering: frames never interleave; grant fixed for whole frame.
//  enable low mid-frame: current frame completes; no new frame starts.
//  ch_valid of grant dropping mid-frame: stall only; grant kept.
//  Reset mid-frame: abandon frame, all outputs to reset values next cycle; no frame_done.
//  Count width: $clog2(FRAME_LEN+1); no wrap beyond FRAME_LEN-1.
//  Back-to-back: IDLE costs one cycle between frames (max throughput FRAME_LEN words per FRAME_LEN+3 cycles).
//  busy: high in HDR/CHID/DATA; low in IDLE; falls the cycle frame_done is asserted.
// TESTING
//  1 Reset, enable=1, only ch2 valid with data 0x0100..0x013F, usb_full=0 -> write stream
//    0xA5A5, 0x0002, 0x0100..0x013F (66 words, consecutive cycles), frame_done one pulse, busy low after.
//  2 All 4 channels always valid -> grant order ch0,ch1,ch2,ch3,ch0; each frame's CHID word matches;
//    no interleaving; exactly 66 writes per frame.
//  3 usb_full asserted 5 cycles during HDR and randomly during DATA -> no write/ch_ready while full,
//    word sequence identical to case 1, total writes still 66.
//  4 ch_valid[grant] toggled 50% during DATA -> samples written in order, no duplicates, no extra
//    ch_ready pulses, other channels' ch_ready stay 0.
//  5 rst pulsed at sample 20 of a frame -> next cycle usb_wr_en=0, busy=0, frame_done=0, ch_ready=0;
//    following frame starts at ch0 with header.
//  6 enable dropped at sample 10 -> current frame completes (frame_done fires), then IDLE held with
//    ch_valid high; re-enable -> next frame granted to next channel in round-robin order.

Source files
------------

// File: rtl/usb_frame_scheduler_if.sv
// Bundle of the beamformer-stream inputs and USB FIFO write-side outputs of usb_frame_scheduler.
// The slave modport is the scheduler itself; master is the surrounding producer/FIFO side.
interface usb_frame_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    logic                       enable;
    logic [NUM_CH-1:0]          ch_valid;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [NUM_CH-1:0]          ch_ready;
    logic                       usb_full;
    logic                       usb_wr_en;
    logic [DATA_W-1:0]          usb_data_out;
    logic                       busy;
    logic                       frame_done;

    modport master (
        output enable, ch_valid, ch_data, usb_full,
        input  ch_ready, usb_wr_en, usb_data_out, busy, frame_done
    );

    modport slave (
        input  enable, ch_valid, ch_data, usb_full,
        output ch_ready, usb_wr_en, usb_data_out, busy, frame_done
    );
endinterface

// File: rtl/usb_frame_scheduler.sv
// Round-robin framer: grants one beamformed stream at a time onto the USB FIFO write port,
// emitting header, channel-ID and FRAME_LEN samples per grant.
module usb_frame_scheduler #(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 16,
    parameter int                FRAME_LEN = 64,
    parameter logic [DATA_W-1:0] HDR_WORD  = 16'hA5A5
) (
    input logic                  clk,
    input logic                  rst,
    usb_frame_scheduler_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, HDR, CHID, DATA} state_t;

    state_t             state;
    logic [CH_W-1:0]    grant;
    logic [CH_W-1:0]    last;
    logic [CNT_W-1:0]   cnt;
    logic [CH_W-1:0]    next_grant;
    logic               accept;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_CH-1:0]  ready;

    logic               vld_p1;
    logic [DATA_W-1:0]  data_p1;
    logic               busy_p1;
    logic               done_p1;

    // First requester after the last grant, wrapping modulo NUM_CH.
    always_comb begin
        int idx;
        logic found;
        next_grant = last;
        found      = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last) + k) % NUM_CH;
            if (!found && bus.ch_valid[idx]) begin
                found      = 1'b1;
                next_grant = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ready  = '0;
        accept = (state == DATA) && !bus.usb_full && bus.ch_valid[grant];
        if (state == DATA)
            ready[grant] = !bus.usb_full && bus.ch_valid[grant];
    end

    assign sel_data     = bus.ch_data[int'(grant)*DATA_W +: DATA_W];
    assign bus.ch_ready = ready;

    // Stage p0 -> p1: FIFO write decision registered onto the output port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= CH_W'(NUM_CH - 1);
            cnt     <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable && |bus.ch_valid) begin
                        grant   <= next_grant;
                        last    <= next_grant;
                        busy_p1 <= 1'b1;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (!bus.usb_full) begin
                        vld_p1  <= 1'b1;
                        data_p1 <= HDR_WORD;
                        state   <= CHID;
                    end
                end
                CHID: begin
                    if (!bus.usb_full) begin
                        vld_p1  <= 1'b1;
                        data_p1 <= DATA_W'(grant);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        vld_p1  <= 1'b1;
                        data_p1 <= sel_data;
                        if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                            cnt     <= '0;
                            busy_p1 <= 1'b0;
                            done_p1 <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.usb_wr_en    = vld_p1;
    assign bus.usb_data_out = data_p1;
    assign bus.busy         = busy_p1;
    assign bus.frame_done   = done_p1;
endmodule

// File: tb/tb_usb_frame_scheduler.sv
// Scoreboard bench for usb_frame_scheduler: directed frames pushed as expected words,
// a negedge monitor pops and compares every FIFO write.
module tb_usb_frame_scheduler;
    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 64;
    localparam logic [15:0] HDR = 16'hA5A5;

    typedef struct {
        logic [15:0] word;
        bit          last;
        bit          chid;
        bit          hdr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_frame_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    usb_frame_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .HDR_WORD(16'hA5A5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        q[$];
    exp_t        e;
    int          idx[NUM_CH];
    logic [15:0] base[NUM_CH];
    int          valid_mode[NUM_CH];
    bit          force_full = 1'b0;
    bit          full_rand  = 1'b0;
    logic [NUM_CH-1:0] pop = '0;
    logic [NUM_CH-1:0] exp_mask;
    bit          full_q    = 1'b0;
    int          cur_grant = 0;
    int          done_cnt  = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          done_cyc  = 0;
    int          d0;

    // Producer model: advance each stream on a handshake, check ch_ready rules.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) if (pop[i]) idx[i]++;
            for (int i = 0; i < NUM_CH; i++) begin
                case (valid_mode[i])
                    0:       bus.ch_valid[i] = 1'b0;
                    1:       bus.ch_valid[i] = 1'b1;
                    default: bus.ch_valid[i] = 1'($urandom_range(0, 1));
                endcase
                bus.ch_data[i*DATA_W +: DATA_W] = base[i] + 16'(idx[i]);
            end
            bus.usb_full = force_full || (full_rand && ($urandom_range(0, 2) == 0));
            #1;
            exp_mask = NUM_CH'(1) << cur_grant;
            if (bus.usb_full || bus.ch_ready != '0) begin
                checks++;
                if ((bus.usb_full && bus.ch_ready != '0) ||
                    ((bus.ch_ready & ~bus.ch_valid) != '0) ||
                    (bus.ch_ready != '0 && bus.ch_ready != exp_mask)) begin
                    failures++;
                    $display("FAIL ready_rules ch_ready=%b ch_valid=%b usb_full=%b required_mask=%b",
                             bus.ch_ready, bus.ch_valid, bus.usb_full, exp_mask);
                end
            end
            pop    = bus.ch_valid & bus.ch_ready;
            full_q = bus.usb_full;
        end
    end

    // Monitor: every write must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (full_q) begin
                checks++;
                if (bus.usb_wr_en) begin
                    failures++;
                    $display("FAIL write_while_full usb_wr_en=1 required=0");
                end
            end
            if (bus.usb_wr_en) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write data=%h required=no write", bus.usb_data_out);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (bus.usb_data_out !== e.word) begin
                        failures++;
                        $display("FAIL word got=%h expected=%h", bus.usb_data_out, e.word);
                    end
                    checks++;
                    if (bus.frame_done !== e.last || bus.busy !== !e.last) begin
                        failures++;
                        $display("FAIL done_busy frame_done=%b busy=%b expected frame_done=%b busy=%b",
                                 bus.frame_done, bus.busy, e.last, !e.last);
                    end
                    if (e.chid) cur_grant = int'(e.word);
                    if (e.hdr)  start_cyc = cyc;
                    if (e.last) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                end
            end else if (bus.frame_done) begin
                checks++;
                failures++;
                $display("FAIL stray_frame_done frame_done=1 required=0");
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_frame(input int ch, input int start, input int n, input bit has_last);
        q.push_back('{word: HDR, last: 1'b0, chid: 1'b0, hdr: 1'b1});
        q.push_back('{word: 16'(ch), last: 1'b0, chid: 1'b1, hdr: 1'b0});
        for (int k = 0; k < n; k++)
            q.push_back('{word: base[ch] + 16'(start + k), last: (has_last && k == n - 1),
                          chid: 1'b0, hdr: 1'b0});
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s frame_done count=%0d expected=%0d", name, done_cnt, target);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) idx[i] = 0;
    endtask

    task automatic all_valid(input int m);
        for (int i = 0; i < NUM_CH; i++) valid_mode[i] = m;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx[i]        = 0;
            valid_mode[i] = 0;
            base[i]       = 16'((i + 1) << 12);
        end
        tick();
        tick();
        check("rst_wr_en", 32'(bus.usb_wr_en), 0);
        check("rst_data", 32'(bus.usb_data_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_ch_ready", 32'(bus.ch_ready), 0);
        rst = 1'b0;

        // Single requester ch2, no back-pressure.
        base[2] = 16'h0100;
        valid_mode[2] = 1;
        tick();
        push_frame(2, 0, FRAME_LEN, 1'b1);
        bus.enable = 1'b1;
        repeat (3) tick();
        bus.enable = 1'b0;
        wait_done(1, 300, "t1_done");
        check("t1_consecutive", 32'(done_cyc - start_cyc), 65);
        repeat (4) tick();
        check("t1_busy_after", 32'(bus.busy), 0);
        check("t1_queue_empty", 32'(q.size()), 0);
        valid_mode[2] = 0;

        // All channels requesting: ch0,ch1,ch2,ch3,ch0.
        rst_pulse();
        all_valid(1);
        tick();
        d0 = done_cnt;
        push_frame(0, 0, FRAME_LEN, 1'b1);
        push_frame(1, 0, FRAME_LEN, 1'b1);
        push_frame(2, 0, FRAME_LEN, 1'b1);
        push_frame(3, 0, FRAME_LEN, 1'b1);
        push_frame(0, FRAME_LEN, FRAME_LEN, 1'b1);
        bus.enable = 1'b1;
        wait_done(d0 + 4, 1000, "t2_four_frames");
        repeat (2) tick();
        bus.enable = 1'b0;
        wait_done(d0 + 5, 300, "t2_fifth_frame");
        check("t2_queue_empty", 32'(q.size()), 0);
        all_valid(0);

        // Back-pressure: full held through HDR, random during DATA.
        rst_pulse();
        base[2] = 16'h0100;
        valid_mode[2] = 1;
        tick();
        d0 = done_cnt;
        push_frame(2, 0, FRAME_LEN, 1'b1);
        force_full = 1'b1;
        bus.enable = 1'b1;
        repeat (5) tick();
        force_full = 1'b0;
        full_rand  = 1'b1;
        bus.enable = 1'b0;
        wait_done(d0 + 1, 600, "t3_done");
        full_rand = 1'b0;
        check("t3_queue_empty", 32'(q.size()), 0);
        valid_mode[2] = 0;
        base[2] = 16'h3000;

        // Granted stream underruns at random; ch3 keeps requesting.
        rst_pulse();
        valid_mode[1] = 1;
        valid_mode[3] = 1;
        tick();
        d0 = done_cnt;
        push_frame(1, 0, FRAME_LEN, 1'b1);
        bus.enable = 1'b1;
        tick();
        valid_mode[1] = 2;
        bus.enable = 1'b0;
        wait_done(d0 + 1, 800, "t4_done");
        check("t4_queue_empty", 32'(q.size()), 0);
        all_valid(0);

        // Reset in the middle of a frame, after sample 20 has been written.
        rst_pulse();
        valid_mode[0] = 1;
        valid_mode[1] = 1;
        valid_mode[2] = 1;
        tick();
        d0 = done_cnt;
        push_frame(0, 0, 20, 1'b0);
        bus.enable = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) tick();
        check("t5_reached_sample20", 32'(q.size()), 0);
        rst = 1'b1;
        tick();
        check("t5_rst_wr_en", 32'(bus.usb_wr_en), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_frame_done", 32'(bus.frame_done), 0);
        check("t5_rst_ch_ready", 32'(bus.ch_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) idx[i] = 0;
        push_frame(0, 0, FRAME_LEN, 1'b1);
        repeat (2) tick();
        bus.enable = 1'b0;
        wait_done(d0 + 1, 300, "t5_restart_done");
        check("t5_queue_empty", 32'(q.size()), 0);

        // Enable dropped mid-frame, then resumed: next grant in rotation.
        d0 = done_cnt;
        push_frame(1, idx[1], FRAME_LEN, 1'b1);
        bus.enable = 1'b1;
        repeat (12) tick();
        bus.enable = 1'b0;
        wait_done(d0 + 1, 300, "t6_first_done");
        for (int n = 0; n < 8; n++) begin
            tick();
            check("t6_idle_busy", 32'(bus.busy), 0);
        end
        push_frame(2, idx[2], FRAME_LEN, 1'b1);
        bus.enable = 1'b1;
        repeat (2) tick();
        bus.enable = 1'b0;
        wait_done(d0 + 2, 300, "t6_second_done");
        repeat (3) tick();
        check("final_queue_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
